id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32: register-file data width.
REQ-002 Parameter REG_AW, default 5: register address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 id_readdata1, id_readdata2  input  DATA_W  register-file read ports for rs/rt.
REQ-006 id_rs, id_rt, id_rd  input  REG_AW  decoded register fields.
REQ-007 id_imm  input  DATA_W  sign-extended immediate.
REQ-008 id_ctrl  input  8  control bundle: regwrite, memread, memwrite, memtoreg, regdst, alusrc, aluop[1:0].
REQ-009 id_valid  input  1  ID holds a real instruction.
REQ-010 flush_ex  input  1  taken branch/jump; kill the instruction entering EX.
REQ-011 wb_regwrite, wb_writereg, wb_writedata  input  1/REG_AW/DATA_W  writeback port, the same values driven to the register file.
REQ-012 ex_a, ex_b, ex_imm  output  DATA_W  registered operands.
REQ-013 ex_rs, ex_rt, ex_rd  output  REG_AW  registered fields.
REQ-014 ex_ctrl  output  8  registered control bundle.
REQ-015 ex_valid  output  1  EX holds a real instruction.
REQ-016 stall  output  1  combinational load-use stall; freezes PC and IF/ID.
REQ-017 stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-018 The block is a one-cycle pipeline register: ID values present at posedge N appear on ex_* after posedge N.
REQ-019 Hazard: stall = ex_valid & ex_ctrl.memread & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt) & ~flush_ex.
REQ-020 On a stall cycle, the block loads a bubble: ex_ctrl = 0, ex_valid = 0; the data/field outputs hold their previous values.
REQ-021 On flush_ex, the block loads a bubble regardless of stall; flush has priority, and stall reads 0 that cycle.
REQ-022 If id_valid = 0, the block loads ex_valid = 0 and ex_ctrl = 0.
REQ-023 A stall lasts exactly one cycle per load-use pair, because the bubble clears ex_ctrl.memread.
REQ-024 A register index of 0 never causes a hazard.
REQ-025 stall_cnt increments by 1 on every cycle with stall = 1 and saturates at 16'hFFFF with no wrap.

Reset
REQ-026 While rst = 1 at posedge: ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl = 0; ex_valid = 0; stall_cnt = 0.
REQ-027 stall is 0 during and after reset until a valid load reaches EX.
REQ-028 Reset has priority over flush_ex, stall and every capture.

Configuration
REQ-029 Macro ID_EX_WB_BYPASS_EN: when defined, ex_a (resp. ex_b) captures wb_writedata instead of id_readdata1 (resp. id_readdata2) whenever wb_regwrite = 1, wb_writereg != 0 and wb_writereg == id_rs (resp. id_rt).
REQ-030 When the macro is undefined, ex_a and ex_b capture id_readdata1/2 unmodified. This mode relies on the register file's negedge write for same-cycle visibility.

Structure
REQ-031 A shared pipeline package holds the id_ctrl bit-position constants, the ctrl width (8), and the aluop encodings.
REQ-032 The hazard comparator is one sub-module, hazard_detect, instantiated once. It is purely combinational and produces stall.

Verification
REQ-033 Load followed by a dependent instruction: EX holds lw $8 (memread=1, rt=8, valid) and ID holds add with rs=8 -> stall=1 for 1 cycle, next ex_valid=0 and ex_ctrl=0, stall_cnt=1; on the following cycle the add is captured.
REQ-034 Independent instruction: EX holds lw $8 and ID holds add with rs=9, rt=10 -> stall=0, add captured next cycle with ex_a=id_readdata1.
REQ-035 Stall and flush together: EX holds lw $8, ID uses $8, flush_ex=1 -> stall=0 and a bubble is loaded.
REQ-036 Register $0: EX holds lw $0 and ID uses $0 -> stall=0.
REQ-037 Bypass (macro defined): wb_regwrite=1, wb_writereg=5, wb_writedata=32'hDEAD_BEEF, id_rs=5, id_readdata1=0 -> ex_a=32'hDEAD_BEEF. With the macro undefined -> ex_a=0.
REQ-038 Reset mid-stall: rst asserted during a stall cycle -> all outputs 0 next cycle. Separately, force 65540 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ex_stage_pkg                                            |
// | Description : Shared pipeline definitions: control-bundle width, bit     |
// |               positions of each control flag, ALU-op encodings and a     |
// |               small helper for decoding the bundle.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package id_ex_stage_pkg;

  // Width of the decoded control bundle carried down the pipe.
  localparam int c_CTRL_W = 8;

  // Bit positions inside the control bundle (MSB first).
  localparam int c_CTRL_REGWRITE = 7;
  localparam int c_CTRL_MEMREAD  = 6;
  localparam int c_CTRL_MEMWRITE = 5;
  localparam int c_CTRL_MEMTOREG = 4;
  localparam int c_CTRL_REGDST   = 3;
  localparam int c_CTRL_ALUSRC   = 2;
  localparam int c_CTRL_ALUOP_HI = 1;
  localparam int c_CTRL_ALUOP_LO = 0;

  // Saturation ceiling of the load-use stall counter.
  localparam logic [15:0] c_STALL_CNT_MAX = 16'hFFFF;

  // Two-bit ALU operation class decoded in ID and refined in EX.
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,  // loads/stores: address add
    ALUOP_BRANCH = 2'b01,  // beq/bne: subtract and compare
    ALUOP_RTYPE  = 2'b10,  // R-type: funct field selects the op
    ALUOP_IMM    = 2'b11   // immediate arithmetic/logic
  } aluop_e;

  // Structured view of the control bundle; layout matches the bit positions.
  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   regdst;
    logic   alusrc;
    aluop_e aluop;
  } ctrl_t;

  // True when the bundle describes a load (data available only after MEM).
  function automatic logic ctrl_is_load(input logic [c_CTRL_W-1:0] ctrl);
    return ctrl[c_CTRL_MEMREAD];
  endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ex_stage_if                                             |
// | Description : Bus between the decode stage, the writeback port and the   |
// |               ID/EX pipeline register.                                   |
// |   id_*      : decoded instruction presented by ID                        |
// |   flush_ex  : taken branch/jump, kills the instruction entering EX       |
// |   wb_*      : writeback port (same values as driven to the reg file)     |
// |   ex_*      : registered operands/fields/control seen by EX              |
// |   modport slave  : the pipeline register (consumes id/wb, drives ex)     |
// |   modport master : the surrounding pipeline (drives id/wb, reads ex)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);

  // Decode side
  logic [DATA_W-1:0]   id_readdata1;
  logic [DATA_W-1:0]   id_readdata2;
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic [REG_AW-1:0]   id_rd;
  logic [DATA_W-1:0]   id_imm;
  logic [c_CTRL_W-1:0] id_ctrl;
  logic                id_valid;
  logic                flush_ex;

  // Writeback port
  logic                wb_regwrite;
  logic [REG_AW-1:0]   wb_writereg;
  logic [DATA_W-1:0]   wb_writedata;

  // Execute side
  logic [DATA_W-1:0]   ex_a;
  logic [DATA_W-1:0]   ex_b;
  logic [DATA_W-1:0]   ex_imm;
  logic [REG_AW-1:0]   ex_rs;
  logic [REG_AW-1:0]   ex_rt;
  logic [REG_AW-1:0]   ex_rd;
  logic [c_CTRL_W-1:0] ex_ctrl;
  logic                ex_valid;

  modport slave (
    input  id_readdata1, id_readdata2, id_rs, id_rt, id_rd, id_imm,
    input  id_ctrl, id_valid, flush_ex,
    input  wb_regwrite, wb_writereg, wb_writedata,
    output ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl, ex_valid
  );

  modport master (
    output id_readdata1, id_readdata2, id_rs, id_rt, id_rd, id_imm,
    output id_ctrl, id_valid, flush_ex,
    output wb_regwrite, wb_writereg, wb_writedata,
    input  ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl, ex_valid
  );

endinterface : id_ex_stage_if
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_detect                                              |
// | Description : Combinational load-use hazard comparator. Raises o_stall   |
// |               when EX holds a valid load whose destination (rt) is a     |
// |               nonzero register read by the valid instruction in ID, and  |
// |               no flush is killing that instruction.                      |
// | Ports       : i_ex_valid, i_ex_memread, i_ex_rt - instruction in EX      |
// |               i_id_valid, i_id_rs, i_id_rt      - instruction in ID      |
// |               i_flush                           - flush of ID->EX        |
// |               o_stall                           - load-use stall         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  wire logic              i_ex_valid,
  input  wire logic              i_ex_memread,
  input  wire logic [REG_AW-1:0] i_ex_rt,
  input  wire logic              i_id_valid,
  input  wire logic [REG_AW-1:0] i_id_rs,
  input  wire logic [REG_AW-1:0] i_id_rt,
  input  wire logic              i_flush,
  output logic                   o_stall
);

  logic w_ex_is_load;
  logic w_dest_nonzero;
  logic w_src_match;

  assign w_ex_is_load   = i_ex_valid & i_ex_memread;
  // $0 is hardwired to zero, so a load "into" it never produces a dependency.
  assign w_dest_nonzero = (i_ex_rt != '0);
  assign w_src_match    = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);

  // A flush kills the ID instruction anyway, so stalling it would be wasted.
  assign o_stall = w_ex_is_load & w_dest_nonzero & i_id_valid & w_src_match & ~i_flush;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ex_stage                                                |
// | Description : ID/EX pipeline register with load-use hazard detection.    |
// |               Captures decoded operands, register fields and control     |
// |               each cycle; inserts a bubble (ctrl=0, valid=0, data held)  |
// |               on a load-use stall or a flush, and counts stall cycles    |
// |               with a saturating 16-bit counter.                          |
// | Ports       : clk        - clock, all state on rising edge               |
// |               rst        - synchronous active-high reset                 |
// |               bus        - id_ex_stage_if.slave (id/wb in, ex out)       |
// |               stall      - combinational load-use stall (freezes PC/IFID)|
// |               stall_cnt  - saturating count of stall cycles              |
// | Config      : ID_EX_WB_BYPASS_EN - when defined, operands read in ID are |
// |               replaced by the writeback value on a same-cycle write to   |
// |               the same nonzero register. When undefined, the register    |
// |               file's negedge write provides that visibility instead.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  wire logic     clk,
  input  wire logic     rst,
  id_ex_stage_if.slave  bus,
  output logic          stall,
  output logic [15:0]   stall_cnt
);

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_imm;
  logic [REG_AW-1:0]   r_rs;
  logic [REG_AW-1:0]   r_rt;
  logic [REG_AW-1:0]   r_rd;
  logic [c_CTRL_W-1:0] r_ctrl;
  logic                r_valid;
  logic [15:0]         r_stall_cnt;

  logic                w_stall;
  logic                w_bubble;
  logic [DATA_W-1:0]   w_op_a;
  logic [DATA_W-1:0]   w_op_b;

  // -------------------------------------------------------------------------
  // Hazard detection against the instruction currently held in EX
  // -------------------------------------------------------------------------
  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .i_ex_valid   (r_valid),
    .i_ex_memread (ctrl_is_load(r_ctrl)),
    .i_ex_rt      (r_rt),
    .i_id_valid   (bus.id_valid),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_flush      (bus.flush_ex),
    .o_stall      (w_stall)
  );

  // Both a stall and a flush turn the next EX slot into a bubble. Data and
  // fields are left untouched so the bubble costs no datapath toggling.
  assign w_bubble = w_stall | bus.flush_ex;

  // -------------------------------------------------------------------------
  // Operand selection
  // -------------------------------------------------------------------------
`ifdef ID_EX_WB_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;

  assign w_byp_a = bus.wb_regwrite & (bus.wb_writereg != '0) & (bus.wb_writereg == bus.id_rs);
  assign w_byp_b = bus.wb_regwrite & (bus.wb_writereg != '0) & (bus.wb_writereg == bus.id_rt);

  assign w_op_a  = w_byp_a ? bus.wb_writedata : bus.id_readdata1;
  assign w_op_b  = w_byp_b ? bus.wb_writedata : bus.id_readdata2;
`else
  // The writeback port is only observed when the bypass is built in.
  logic w_unused_wb;

  assign w_unused_wb = ^{bus.wb_regwrite, bus.wb_writereg, bus.wb_writedata};

  assign w_op_a = bus.id_readdata1;
  assign w_op_b = bus.id_readdata2;
`endif

  // -------------------------------------------------------------------------
  // ID/EX register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (w_bubble) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_a     <= w_op_a;
      r_b     <= w_op_b;
      r_imm   <= bus.id_imm;
      r_rs    <= bus.id_rs;
      r_rt    <= bus.id_rt;
      r_rd    <= bus.id_rd;
      // A non-instruction in ID must not carry stray control into EX.
      r_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
      r_valid <= bus.id_valid;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating stall counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_STALL_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ex_a     = r_a;
  assign bus.ex_b     = r_b;
  assign bus.ex_imm   = r_imm;
  assign bus.ex_rs    = r_rs;
  assign bus.ex_rt    = r_rt;
  assign bus.ex_rd    = r_rd;
  assign bus.ex_ctrl  = r_ctrl;
  assign bus.ex_valid = r_valid;

  assign stall        = w_stall;
  assign stall_cnt    = r_stall_cnt;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_ex_stage                                             |
// | Description : Self-checking bench for id_ex_stage. A behavioural model   |
// |               of "what EX holds" and "how many stalls happened" is       |
// |               advanced every clock and compared with the DUT, using      |
// |               directed scenarios and a randomized stream.                |
// |               Honours ID_EX_WB_BYPASS_EN in the model.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int VEC_W  = 3*DATA_W + 3*REG_AW + c_CTRL_W + 1;

  // lw: regwrite, memread, memtoreg, alusrc, aluop=add
  localparam logic [7:0] c_CTRL_LW  = 8'hD4;
  // add: regwrite, regdst, aluop=rtype
  localparam logic [7:0] c_CTRL_ADD = 8'h8A;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [15:0] stall_cnt;

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------
  // Reference model: the instruction slot in EX plus a stall tally
  // ---------------------------------------------------------------------
  typedef struct {
    logic [DATA_W-1:0] a, b, imm;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [7:0]        ctrl;
    logic              valid;
  } ex_slot_t;

  ex_slot_t m;
  int       m_cnt;

  // Load-use: a valid load in EX writes a nonzero register that ID reads.
  function automatic bit model_hazard();
    bit ex_load = m.valid && m.ctrl[c_CTRL_MEMREAD];
    bit reads   = (m.rt == bus.id_rs) || (m.rt == bus.id_rt);
    return ex_load && (m.rt != 0) && bus.id_valid && reads && !bus.flush_ex;
  endfunction

  function automatic logic [DATA_W-1:0] model_operand(input logic [REG_AW-1:0] src,
                                                      input logic [DATA_W-1:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    if (bus.wb_regwrite && bus.wb_writereg != 0 && bus.wb_writereg == src)
      return bus.wb_writedata;
`endif
    return rf;
  endfunction

  function automatic logic [VEC_W-1:0] model_vec();
    return {m.a, m.b, m.imm, m.rs, m.rt, m.rd, m.ctrl, m.valid};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {bus.ex_a, bus.ex_b, bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd,
            bus.ex_ctrl, bus.ex_valid};
  endfunction

  // Advance one clock; model state is computed from the inputs at the edge.
  task automatic tick();
    ex_slot_t nxt;
    bit       h;
    h   = model_hazard();
    nxt = m;
    if (rst) begin
      nxt   = '{a: '0, b: '0, imm: '0, rs: '0, rt: '0, rd: '0, ctrl: '0, valid: 1'b0};
    end else if (h || bus.flush_ex) begin
      nxt.ctrl  = '0;
      nxt.valid = 1'b0;
    end else begin
      nxt.a     = model_operand(bus.id_rs, bus.id_readdata1);
      nxt.b     = model_operand(bus.id_rt, bus.id_readdata2);
      nxt.imm   = bus.id_imm;
      nxt.rs    = bus.id_rs;
      nxt.rt    = bus.id_rt;
      nxt.rd    = bus.id_rd;
      nxt.ctrl  = bus.id_valid ? bus.id_ctrl : 8'h00;
      nxt.valid = bus.id_valid;
    end
    @(posedge clk);
    m = nxt;
    if (rst)      m_cnt = 0;
    else if (h)   m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [7:0] c,
                        input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                        input logic [REG_AW-1:0] rd,
                        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                        input logic [DATA_W-1:0] im);
    bus.id_valid     = v;
    bus.id_ctrl      = c;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_readdata1 = d1;
    bus.id_readdata2 = d2;
    bus.id_imm       = im;
  endtask

  task automatic quiet_wb();
    bus.wb_regwrite  = 1'b0;
    bus.wb_writereg  = '0;
    bus.wb_writedata = '0;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.flush_ex     = 1'b0;
    bus.wb_regwrite  = 1'b1;
    bus.wb_writereg  = 5'd3;
    bus.wb_writedata = $urandom;
    set_id(1'b1, c_CTRL_LW, 5'd3, 5'd3, 5'd7, $urandom, $urandom, $urandom);
    tick();
    tick();
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    total++;
    if (stall_cnt !== 16'h0000) begin
      bad++; $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    rst = 1'b0;
    quiet_wb();
    set_id(1'b0, 8'h00, '0, '0, '0, '0, '0, '0);
    tick();
  endtask

  task automatic test_load_use();
    int cnt0 = m_cnt;
    set_id(1'b1, c_CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h0000_1000, 32'h0, 32'h10);
    tick();
    set_id(1'b1, c_CTRL_ADD, 5'd8, 5'd9, 5'd11, 32'h1111_0000, 32'h2222_0000, 32'h0);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL ldu_stall_raised: got %b want 1", stall);
    end
    tick();
    total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00) begin
      bad++; $display("FAIL ldu_bubble: got valid=%b ctrl=%h want 0/00", bus.ex_valid, bus.ex_ctrl);
    end
    total++;
    if (bus.ex_a !== 32'h0000_1000 || bus.ex_rt !== 5'd8) begin
      bad++; $display("FAIL ldu_bubble_hold: got a=%h rt=%0d want 00001000/8", bus.ex_a, bus.ex_rt);
    end
    total++;
    if (int'(stall_cnt) !== cnt0 + 1) begin
      bad++; $display("FAIL ldu_stall_cnt: got %0d want %0d", stall_cnt, cnt0 + 1);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL ldu_single_stall: got %b want 0", stall);
    end
    tick();
    total++;
    if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'h1111_0000 || bus.ex_ctrl !== c_CTRL_ADD) begin
      bad++; $display("FAIL ldu_capture: got valid=%b a=%h ctrl=%h want 1/11110000/%h",
                      bus.ex_valid, bus.ex_a, bus.ex_ctrl, c_CTRL_ADD);
    end
  endtask

  task automatic test_independent();
    set_id(1'b1, c_CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h0, 32'h0, 32'h4);
    tick();
    set_id(1'b1, c_CTRL_ADD, 5'd9, 5'd10, 5'd12, 32'hCAFE_0001, 32'hCAFE_0002, 32'h0);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL indep_stall: got %b want 0", stall);
    end
    tick();
    total++;
    if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'hCAFE_0001 || bus.ex_b !== 32'hCAFE_0002) begin
      bad++; $display("FAIL indep_capture: got valid=%b a=%h b=%h want 1/cafe0001/cafe0002",
                      bus.ex_valid, bus.ex_a, bus.ex_b);
    end
  endtask

  task automatic test_flush();
    int cnt0;
    set_id(1'b1, c_CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h0, 32'h0, 32'h8);
    tick();
    cnt0 = m_cnt;
    set_id(1'b1, c_CTRL_ADD, 5'd1, 5'd8, 5'd13, 32'h5, 32'h6, 32'h0);
    bus.flush_ex = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL flush_stall: got %b want 0", stall);
    end
    tick();
    bus.flush_ex = 1'b0;
    total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || int'(stall_cnt) !== cnt0) begin
      bad++; $display("FAIL flush_bubble: got valid=%b ctrl=%h cnt=%0d want 0/00/%0d",
                      bus.ex_valid, bus.ex_ctrl, stall_cnt, cnt0);
    end
  endtask

  task automatic test_zero_reg();
    set_id(1'b1, c_CTRL_LW, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    set_id(1'b1, c_CTRL_ADD, 5'd0, 5'd0, 5'd14, 32'h0, 32'h0, 32'h0);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL zero_reg_stall: got %b want 0", stall);
    end
    tick();
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
    set_id(1'b1, c_CTRL_ADD, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0000_0066, 32'h0);
    bus.wb_regwrite  = 1'b1;
    bus.wb_writereg  = 5'd5;
    bus.wb_writedata = 32'hDEAD_BEEF;
`ifdef ID_EX_WB_BYPASS_EN
    exp_a = 32'hDEAD_BEEF;
`else
    exp_a = 32'h0;
`endif
    tick();
    total++;
    if (bus.ex_a !== exp_a || bus.ex_b !== 32'h0000_0066) begin
      bad++; $display("FAIL bypass_rs: got a=%h b=%h want %h/00000066", bus.ex_a, bus.ex_b, exp_a);
    end
    // rt side, and a write to $0 that must never be forwarded.
    set_id(1'b1, c_CTRL_ADD, 5'd0, 5'd6, 5'd7, 32'h0000_0011, 32'h0000_0022, 32'h0);
    bus.wb_writereg  = 5'd6;
    bus.wb_writedata = 32'h1234_5678;
`ifdef ID_EX_WB_BYPASS_EN
    exp_b = 32'h1234_5678;
`else
    exp_b = 32'h0000_0022;
`endif
    tick();
    total++;
    if (bus.ex_a !== 32'h0000_0011 || bus.ex_b !== exp_b) begin
      bad++; $display("FAIL bypass_rt: got a=%h b=%h want 00000011/%h", bus.ex_a, bus.ex_b, exp_b);
    end
    set_id(1'b1, c_CTRL_ADD, 5'd0, 5'd0, 5'd7, 32'h0000_0033, 32'h0000_0044, 32'h0);
    bus.wb_writereg  = 5'd0;
    tick();
    total++;
    if (bus.ex_a !== 32'h0000_0033 || bus.ex_b !== 32'h0000_0044) begin
      bad++; $display("FAIL bypass_zero: got a=%h b=%h want 00000033/00000044", bus.ex_a, bus.ex_b);
    end
    quiet_wb();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, c_CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h77, 32'h88, 32'h99);
    tick();
    set_id(1'b1, c_CTRL_ADD, 5'd8, 5'd8, 5'd15, 32'h1, 32'h2, 32'h3);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL rst_mid_stall_pre: got %b want 1", stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (dut_vec() !== '0 || stall_cnt !== 16'h0000) begin
      bad++; $display("FAIL rst_mid_stall: got ex=%h cnt=%h want 0/0000", dut_vec(), stall_cnt);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL rst_mid_stall_after: got %b want 0", stall);
    end
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c;
      c = 8'($urandom);
      c[c_CTRL_MEMREAD] = ($urandom_range(0, 2) == 0);
      rst          = ($urandom_range(0, 63) == 0);
      bus.flush_ex = ($urandom_range(0, 7) == 0);
      set_id(($urandom_range(0, 7) != 0), c, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom, $urandom);
      bus.wb_regwrite  = 1'($urandom);
      bus.wb_writereg  = 5'($urandom_range(0, 3));
      bus.wb_writedata = $urandom;
      #1;
      if (!rst) begin
        total++;
        if (stall !== model_hazard()) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, model_hazard());
        end
      end
      tick();
      total++;
      if (dut_vec() !== model_vec() || int'(stall_cnt) !== m_cnt) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_ex[%0d]: got %h cnt=%0d want %h cnt=%0d",
                                i, dut_vec(), stall_cnt, model_vec(), m_cnt);
      end
    end
    rst = 1'b0;
    bus.flush_ex = 1'b0;
    quiet_wb();
  endtask

  // Preloads the counter close to its ceiling, then drives real stalls.
  task automatic test_saturation();
    force dut.r_stall_cnt = 16'hFFFC;
    #1;
    release dut.r_stall_cnt;
    m_cnt = 16'hFFFC;
    // A load that reads its own destination stalls every other cycle.
    set_id(1'b1, c_CTRL_LW, 5'd8, 5'd8, 5'd0, 32'hA, 32'hB, 32'hC);
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (int'(stall_cnt) !== m_cnt) begin
        bad++; $display("FAIL sat_step[%0d]: got %0d want %0d", i, stall_cnt, m_cnt);
      end
    end
    total++;
    if (stall_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL sat_ceiling: got %h want ffff", stall_cnt);
    end
  endtask

  initial begin
    m     = '{a: '0, b: '0, imm: '0, rs: '0, rt: '0, rd: '0, ctrl: '0, valid: 1'b0};
    m_cnt = 0;
    rst   = 1'b1;
    quiet_wb();
    bus.flush_ex = 1'b0;
    set_id(1'b0, 8'h00, '0, '0, '0, '0, '0, '0);
    test_reset();
    test_load_use();
    test_independent();
    test_flush();
    test_zero_reg();
    test_bypass();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
